// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, delay line, optional padding + CRC-32 FCS, IFG.
// Build option GMII_TX_PAD_FCS_EN enables the PAD/FCS path; without it frames go DATA -> IFG.
module gmii_tx_framer #(
   parameter int unsigned MIN_BYTES = 60,
   parameter int unsigned IFG_BYTES = 12
) (
   input  logic        gmii_tx_clk,
   input  logic        rst_n,
   input  logic        in_en,
   input  logic [7:0]  in_d,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   typedef enum logic [2:0] {StIdle, StPre, StData, StPad, StFcs, StIfg} state_e;

   localparam logic [15:0] IfgLast = 16'(IFG_BYTES - 1);

   state_e            state_q, state_d;
   logic [15:0]       cyc_q, cyc_d;
   logic              prev_q;
   logic [7:0]        smp_q;
   logic              smp_v_q, smp_v_d;
   logic [7:0][7:0]   dl_q;
   logic [7:0]        dl_v_q;
   logic              out_en_q, out_en_d;
   logic [7:0]        out_d_q, out_d_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic              rise, accept, data_last;

`ifdef GMII_TX_PAD_FCS_EN
   localparam logic [10:0] MinCnt = 11'(MIN_BYTES);

   logic [31:0] crc_q, crc_d, fcs_word;
   logic [10:0] cnt_q, cnt_d, cnt_inc;

   // Reflected CRC-32, one byte per call.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign fcs_word = ~crc_q;
`endif

   assign rise      = in_en & ~prev_q;
   assign accept    = rise & (state_q == StIdle);
   // Valid bytes are contiguous, so an empty next-to-tail slot means this is the last byte.
   assign data_last = (state_q == StData) & ~dl_v_q[6];
   assign smp_v_d   = in_en & (accept | smp_v_q);

   // State register
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StPre;
               cyc_d   = '0;
            end
         end
         StPre: begin
            cyc_d = cyc_q + 16'd1;
            if (cyc_q == 16'd7) begin
               state_d = StData;
               cyc_d   = '0;
            end
         end
         StData: begin
            if (data_last) begin
               cyc_d = '0;
`ifdef GMII_TX_PAD_FCS_EN
               state_d = (cnt_inc < MinCnt) ? StPad : StFcs;
`else
               state_d = StIfg;
`endif
            end
         end
`ifdef GMII_TX_PAD_FCS_EN
         StPad: begin
            if (cnt_inc == MinCnt) begin
               state_d = StFcs;
               cyc_d   = '0;
            end
         end
         StFcs: begin
            cyc_d = cyc_q + 16'd1;
            if (cyc_q == 16'd3) begin
               state_d = StIfg;
               cyc_d   = '0;
            end
         end
`endif
         StIfg: begin
            cyc_d = cyc_q + 16'd1;
            if (cyc_q == IfgLast) begin
               state_d = StIdle;
               cyc_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cyc_d   = '0;
         end
      endcase
   end

   // Output logic (registered one cycle later)
   always_comb begin
      out_en_d = 1'b0;
      out_d_d  = 8'h00;
      unique case (state_q)
         StPre: begin
            out_en_d = 1'b1;
            out_d_d  = (cyc_q == 16'd7) ? 8'hD5 : 8'h55;
         end
         StData: begin
            out_en_d = 1'b1;
            out_d_d  = dl_q[7];
         end
`ifdef GMII_TX_PAD_FCS_EN
         StPad: begin
            out_en_d = 1'b1;
            out_d_d  = 8'h00;
         end
         StFcs: begin
            out_en_d = 1'b1;
            out_d_d  = fcs_word[{cyc_q[1:0], 3'b000} +: 8];
         end
`endif
         default: begin
            out_en_d = 1'b0;
            out_d_d  = 8'h00;
         end
      endcase
   end

   // Counters and CRC
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (rise && (state_q != StIdle)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
`ifdef GMII_TX_PAD_FCS_EN
      crc_d = crc_q;
      cnt_d = cnt_q;
      if (accept) begin
         crc_d = 32'hFFFFFFFF;
         cnt_d = '0;
      end else if (state_q == StData) begin
         crc_d = crc_byte(crc_q, dl_q[7]);
         cnt_d = cnt_inc;
      end else if (state_q == StPad) begin
         crc_d = crc_byte(crc_q, 8'h00);
         cnt_d = cnt_inc;
      end
      if ((state_q == StFcs) && (cyc_q == 16'd3)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
`else
      if (data_last) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
`endif
   end

   // Datapath registers; prev_q resets high so a frame in flight at reset release is ignored
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q      <= 1'b1;
         smp_q       <= '0;
         smp_v_q     <= 1'b0;
         dl_q        <= '0;
         dl_v_q      <= '0;
         out_en_q    <= 1'b0;
         out_d_q     <= '0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
`ifdef GMII_TX_PAD_FCS_EN
         crc_q       <= 32'hFFFFFFFF;
         cnt_q       <= '0;
`endif
      end else begin
         prev_q      <= in_en;
         smp_q       <= in_d;
         smp_v_q     <= smp_v_d;
         dl_q        <= {dl_q[6:0], smp_q};
         dl_v_q      <= {dl_v_q[6:0], smp_v_q};
         out_en_q    <= out_en_d;
         out_d_q     <= out_d_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
`ifdef GMII_TX_PAD_FCS_EN
         crc_q       <= crc_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign gmii_tx_en = out_en_q;
   assign gmii_txd   = out_d_q;
   assign frame_cnt  = frame_cnt_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomized bench for gmii_tx_framer against a frame-level reference model.
// Follows GMII_TX_PAD_FCS_EN the same way the design does.
module tb_gmii_tx_framer;

   localparam int unsigned MinBytes = 60;
   localparam int unsigned IfgBytes = 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_en;
   logic [7:0]  in_d;
   logic        gmii_tx_en;
   logic [7:0]  gmii_txd;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   gmii_tx_framer #(
      .MIN_BYTES(MinBytes),
      .IFG_BYTES(IfgBytes)
   ) dut (
      .gmii_tx_clk(clk),
      .rst_n      (rst_n),
      .in_en      (in_en),
      .in_d       (in_d),
      .gmii_tx_en (gmii_tx_en),
      .gmii_txd   (gmii_txd),
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt)
   );

   always #4 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] exp_byte_q[$];
   int         exp_len_q[$];
   int         exp_start_q[$];
   int         next_ok = 0;
   int         exp_frames = 0;
   int         exp_drops = 0;

   // Monitor state
   logic [7:0] cap[$];
   bit         in_frame = 0;
   bit         seen = 0;
   int         start_cyc = 0;
   int         low_run = 0;
   int         bad_idle = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_bits(input logic [7:0] q[$], input int from);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFFFFFF;
      for (int i = from; i < q.size(); i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ q[i][b];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
         end
      end
      return c;
   endfunction

   function automatic int on_len(input int n);
`ifdef GMII_TX_PAD_FCS_EN
      return 12 + ((n < MinBytes) ? MinBytes : n);
`else
      return 8 + n;
`endif
   endfunction

   task automatic build_expected(input logic [7:0] pl[$], input int t);
      logic [7:0] f[$];
      logic [7:0] body[$];
      logic [31:0] fcs;
      f = {};
      for (int i = 0; i < 7; i++) f.push_back(8'h55);
      f.push_back(8'hD5);
      body = pl;
`ifdef GMII_TX_PAD_FCS_EN
      while (body.size() < MinBytes) body.push_back(8'h00);
      fcs = ~crc_bits(body, 0);
      for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
`else
      fcs = 32'h0;
`endif
      foreach (body[i]) f.push_back(body[i]);
      foreach (f[i]) exp_byte_q.push_back(f[i]);
      exp_len_q.push_back(f.size());
      exp_start_q.push_back(t + 1);
   endtask

   task automatic model_clear();
      exp_byte_q.delete();
      exp_len_q.delete();
      exp_start_q.delete();
      next_ok    = 0;
      exp_frames = 0;
      exp_drops  = 0;
   endtask

   task automatic finish_frame();
      int len, st, nbad;
      logic [7:0] b;
      if (exp_len_q.size() == 0) begin
         check("unexpected_frame", cap.size(), 0);
         return;
      end
      len  = exp_len_q.pop_front();
      st   = exp_start_q.pop_front();
      nbad = 0;
      check("frame_len", cap.size(), len);
      check("frame_start", start_cyc, st);
      for (int i = 0; i < len; i++) begin
         b = exp_byte_q.pop_front();
         if (i >= cap.size() || cap[i] !== b) nbad++;
      end
      check("frame_bytes_bad", nbad, 0);
`ifdef GMII_TX_PAD_FCS_EN
      check("fcs_residue", crc_bits(cap, 8), 32'hDEBB20E3);
`endif
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         cap      = {};
         in_frame = 0;
         seen     = 0;
         low_run  = 0;
      end else if (gmii_tx_en) begin
         if (!in_frame) begin
            in_frame  = 1;
            cap       = {};
            start_cyc = cyc;
            if (seen) check("ifg_gap_ok", (low_run >= IfgBytes), 1);
         end
         cap.push_back(gmii_txd);
      end else begin
         if (in_frame) begin
            in_frame = 0;
            finish_frame();
            seen    = 1;
            low_run = 0;
         end
         low_run++;
         if (gmii_txd !== 8'h00) bad_idle++;
      end
   end

   // Entry/exit aligned 1 time unit after a rising edge with in_en low.
   task automatic send_frame(input int n, input int mode, input int gap);
      logic [7:0] pl[$];
      int t;
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back((mode == 0) ? 8'(i) : 8'($urandom));
      t = cyc + 1;
      if (t >= next_ok) begin
         build_expected(pl, t);
         exp_frames++;
         next_ok = t + on_len(n) + IfgBytes + 1;
      end else begin
         exp_drops++;
      end
      for (int i = 0; i < n; i++) begin
         in_en = 1'b1;
         in_d  = pl[i];
         @(posedge clk); #1;
      end
      in_en = 1'b0;
      in_d  = 8'h00;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_len_q.size() != 0 || gmii_tx_en || cyc < next_ok) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_done", (n < 5000), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout cyc=%0d required=finish", cyc);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      in_en = 1'b0;
      in_d  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_en", gmii_tx_en, 0);
      check("rst_txd", gmii_txd, 8'h00);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 64-byte incrementing frame, then a short random frame
      send_frame(64, 0, 2);
      wait_drain();
      check("t1_frame_cnt", frame_cnt, exp_frames);
      send_frame(20, 1, 2);
      wait_drain();
      check("t2_frame_cnt", frame_cnt, exp_frames);

      // Second frame rises 5 cycles after the first ends: dropped
      do_reset();
      send_frame(30, 1, 5);
      send_frame(10, 1, 1);
      wait_drain();
      send_frame(25, 1, 1);
      wait_drain();
      check("t3_drop_cnt", drop_cnt, exp_drops);
      check("t3_frame_cnt", frame_cnt, exp_frames);

      // in_en already high at reset release: ignored, not counted as drop
      rst_n = 1'b0;
      model_clear();
      in_en = 1'b1;
      repeat (3) begin
         in_d = 8'($urandom);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      repeat (20) begin
         in_d = 8'($urandom);
         @(posedge clk); #1;
      end
      in_en = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("t4_drop_cnt", drop_cnt, 0);
      check("t4_frame_cnt", frame_cnt, 0);
      send_frame(15, 1, 1);
      wait_drain();
      check("t4_next_frame_cnt", frame_cnt, exp_frames);

      // Reset pulse while the frame is in DATA
      for (int i = 0; i < 15; i++) begin
         in_en = 1'b1;
         in_d  = 8'($urandom);
         @(posedge clk); #1;
      end
      check("t5_busy_before_rst", gmii_tx_en, 1);
      #1;
      rst_n = 1'b0;
      model_clear();
      in_en = 1'b0;
      #1;
      check("t5_rst_tx_en", gmii_tx_en, 0);
      check("t5_rst_txd", gmii_txd, 8'h00);
      check("t5_rst_frame_cnt", frame_cnt, 0);
      check("t5_rst_drop_cnt", drop_cnt, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(MinBytes + 10, 1, 1);
      wait_drain();
      check("t5_frame_cnt", frame_cnt, exp_frames);

      // Random lengths and gaps; some frames land inside the IFG and get dropped
      for (int k = 0; k < 40; k++) begin
         send_frame($urandom_range(1, 120), 1, $urandom_range(1, 40));
      end
      wait_drain();
      check("rand_frame_cnt", frame_cnt, exp_frames);
      check("rand_drop_cnt", drop_cnt, exp_drops);

      check("idle_txd_nonzero", bad_idle, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
